// File: rtl/writeback_arbiter.sv
// Merges execute results and buffered load returns onto the single register-file write port.
// Optional build macro: WB_X0_FILTER_EN suppresses the write enable for grants targeting x0.
module writeback_arbiter #(
  parameter int LOAD_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               exValid,
  output logic                               exReady,
  input  logic [4:0]                         exRdAddr,
  input  logic [31:0]                        exData,
  input  logic                               ldValid,
  output logic                               ldReady,
  input  logic [4:0]                         ldRdAddr,
  input  logic [31:0]                        ldData,
  output logic                               wEnable,
  output logic [4:0]                         rdAddr,
  output logic [31:0]                        wData,
  output logic [$clog2(LOAD_FIFO_DEPTH):0]   pendingCount
);

  localparam int PW = $clog2(LOAD_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C      = CW'(LOAD_FIFO_DEPTH);
  localparam logic [SW-1:0] STARVE_MAX_C = SW'(STARVE_LIMIT);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_entry_t;

  wb_entry_t         mem_q [LOAD_FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              wen_q, wen_d;
  logic [4:0]        addr_q, addr_d;
  logic [31:0]       data_q, data_d;

  logic              fifo_full, fifo_nonempty, force_drain;
  logic              push, pop, ex_grant, grant;
  wb_entry_t         grant_entry;

  // Arbitration: a full FIFO or a starved head pre-empts execute.
  always_comb begin
    fifo_full     = (count_q == DEPTH_C);
    fifo_nonempty = (count_q != '0);
    force_drain   = fifo_nonempty && (fifo_full || starve_q == STARVE_MAX_C);
    exReady       = !force_drain;
    ldReady       = !fifo_full;
    push          = ldValid && ldReady;
    pop           = fifo_nonempty && (!exValid || force_drain);
    ex_grant      = !pop && exValid && exReady;
    grant         = pop || ex_grant;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant_entry = '{addr: exRdAddr, data: exData};
    if (pop) grant_entry = mem_q[rd_ptr_q];

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);

    starve_d = starve_q;
    if (pop || !fifo_nonempty) starve_d = '0;
    else if (starve_q != STARVE_MAX_C) starve_d = starve_q + 1'b1;

`ifdef WB_X0_FILTER_EN
    wen_d = grant && (grant_entry.addr != 5'd0);
`else
    wen_d = grant;
`endif
    addr_d = grant ? grant_entry.addr : addr_q;
    data_d = grant ? grant_entry.data : data_q;
  end

  // NOTE: FIFO storage carries no reset; validity is tracked solely by count and pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{addr: ldRdAddr, data: ldData};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign wEnable      = wen_q;
  assign rdAddr       = addr_q;
  assign wData        = data_q;
  assign pendingCount = count_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: expected writes are queued at issue time and a
// negedge monitor compares every register-file write against the queue head.
module tb_writeback_arbiter;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        exValid, exReady, ldValid, ldReady, wEnable;
  logic [4:0]  exRdAddr, ldRdAddr, rdAddr;
  logic [31:0] exData, ldData, wData;
  logic [2:0]  pendingCount;

  int  n_checks = 0;
  int  n_fail   = 0;
  wb_t sb[$];
  wb_t ld_model[$];
  wb_t mon_e;

  writeback_arbiter #(.LOAD_FIFO_DEPTH(4), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .exValid(exValid), .exReady(exReady), .exRdAddr(exRdAddr), .exData(exData),
    .ldValid(ldValid), .ldReady(ldReady), .ldRdAddr(ldRdAddr), .ldData(ldData),
    .wEnable(wEnable), .rdAddr(rdAddr), .wData(wData), .pendingCount(pendingCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && wEnable) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got rdAddr=%0d wData=0x%08h, expected no write (t=%0t)",
                 rdAddr, wData, $time);
      end else begin
        mon_e = sb.pop_front();
        check("wb_rdAddr", 32'(rdAddr), 32'(mon_e.addr));
        check("wb_wData", wData, mon_e.data);
      end
    end
  end

  // One stimulus cycle. g: 0 = no grant, 1 = execute granted, 2 = FIFO head granted.
  task automatic cyc(input logic exv, input logic [4:0] exa, input logic [31:0] exd,
                     input logic ldv, input logic [4:0] lda, input logic [31:0] ldd,
                     input int g, input logic e_exr, input logic e_ldr, input int e_cnt);
    @(posedge clk);
    #1;
    exValid = exv; exRdAddr = exa; exData = exd;
    ldValid = ldv; ldRdAddr = lda; ldData = ldd;
    #1;
    check("exReady", 32'(exReady), 32'(e_exr));
    check("ldReady", 32'(ldReady), 32'(e_ldr));
    check("pendingCount", 32'(pendingCount), 32'(e_cnt));
    if (g == 1) begin
`ifdef WB_X0_FILTER_EN
      if (exa != 5'd0) sb.push_back('{addr: exa, data: exd});
`else
      sb.push_back('{addr: exa, data: exd});
`endif
    end else if (g == 2) begin
      sb.push_back(ld_model.pop_front());
    end
    if (ldv && e_ldr) ld_model.push_back('{addr: lda, data: ldd});
  endtask

  task automatic idle(input int e_cnt);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 0, 1'b1, 1'b1, e_cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    exValid = 1'b0; exRdAddr = '0; exData = '0;
    ldValid = 1'b0; ldRdAddr = '0; ldData = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_wEnable", 32'(wEnable), 32'd0);
    check("reset_pendingCount", 32'(pendingCount), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset mid-traffic with three loads queued; the last execute write is still in flight.
    cyc(1'b1, 5'd1, 32'hE000_0000, 1'b1, 5'd10, 32'hAAAA_0001, 1, 1'b1, 1'b1, 0);
    cyc(1'b1, 5'd2, 32'hE000_0001, 1'b1, 5'd11, 32'hAAAA_0002, 1, 1'b1, 1'b1, 1);
    cyc(1'b1, 5'd3, 32'hE000_0002, 1'b1, 5'd12, 32'hAAAA_0003, 0, 1'b1, 1'b1, 2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exValid = 1'b0; ldValid = 1'b0;
    ld_model.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_pendingCount", 32'(pendingCount), 32'd0);
      check("rst_wEnable", 32'(wEnable), 32'd0);
      check("rst_rdAddr", 32'(rdAddr), 32'd0);
      check("rst_wData", wData, 32'd0);
      @(posedge clk);
    end
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_no_write", 32'(wEnable), 32'd0);

    // Single execute write with an empty FIFO, then hold of rdAddr when idle.
    cyc(1'b1, 5'd5, 32'h0000_1234, 1'b0, 5'd0, 32'h0, 1, 1'b1, 1'b1, 0);
    idle(0);
    @(negedge clk);
    check("ex_wEnable", 32'(wEnable), 32'd1);
    check("ex_rdAddr", 32'(rdAddr), 32'd5);
    check("ex_wData", wData, 32'h0000_1234);
    idle(0);
    @(negedge clk);
    check("idle_wEnable", 32'(wEnable), 32'd0);
    check("idle_rdAddr_hold", 32'(rdAddr), 32'd5);

    // Anti-starvation: one load waits through four execute grants, then is forced out.
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h0000_DEAD, 0, 1'b1, 1'b1, 0);
    cyc(1'b1, 5'd1, 32'h0000_0101, 1'b0, 5'd0, 32'h0, 1, 1'b1, 1'b1, 1);
    cyc(1'b1, 5'd2, 32'h0000_0102, 1'b0, 5'd0, 32'h0, 1, 1'b1, 1'b1, 1);
    cyc(1'b1, 5'd3, 32'h0000_0103, 1'b0, 5'd0, 32'h0, 1, 1'b1, 1'b1, 1);
    cyc(1'b1, 5'd4, 32'h0000_0104, 1'b0, 5'd0, 32'h0, 1, 1'b1, 1'b1, 1);
    cyc(1'b1, 5'd5, 32'h0000_0105, 1'b0, 5'd0, 32'h0, 2, 1'b0, 1'b1, 1);
    cyc(1'b1, 5'd5, 32'h0000_0105, 1'b0, 5'd0, 32'h0, 1, 1'b1, 1'b1, 0);
    idle(0);

    // Fill to full behind execute traffic; full forces drains and blocks both producers.
    cyc(1'b1, 5'd1, 32'h1111_0001, 1'b1, 5'd21, 32'h2222_0001, 1, 1'b1, 1'b1, 0);
    cyc(1'b1, 5'd2, 32'h1111_0002, 1'b1, 5'd22, 32'h2222_0002, 1, 1'b1, 1'b1, 1);
    cyc(1'b1, 5'd3, 32'h1111_0003, 1'b1, 5'd23, 32'h2222_0003, 1, 1'b1, 1'b1, 2);
    cyc(1'b1, 5'd4, 32'h1111_0004, 1'b1, 5'd24, 32'h2222_0004, 1, 1'b1, 1'b1, 3);
    cyc(1'b1, 5'd6, 32'h1111_0005, 1'b1, 5'd25, 32'h2222_0005, 2, 1'b0, 1'b0, 4);
    cyc(1'b1, 5'd6, 32'h1111_0005, 1'b1, 5'd25, 32'h2222_0005, 1, 1'b1, 1'b1, 3);
    cyc(1'b1, 5'd7, 32'h1111_0006, 1'b0, 5'd0, 32'h0, 2, 1'b0, 1'b0, 4);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 2, 1'b1, 1'b1, 3);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 2, 1'b1, 1'b1, 2);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 2, 1'b1, 1'b1, 1);
    idle(0);

    // Steady push+pop at occupancy 2; eight entries wrap the pointers twice.
    cyc(1'b1, 5'd8, 32'h3333_0001, 1'b1, 5'd9, 32'h4444_0000, 1, 1'b1, 1'b1, 0);
    cyc(1'b1, 5'd9, 32'h3333_0002, 1'b1, 5'd9, 32'h4444_0001, 1, 1'b1, 1'b1, 1);
    for (int i = 0; i < 8; i++)
      cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'(16 + i), 32'h4444_0002 + 32'(i), 2, 1'b1, 1'b1, 2);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 2, 1'b1, 1'b1, 2);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 2, 1'b1, 1'b1, 1);
    idle(0);

    // Execute write to x0.
    cyc(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0, 1, 1'b1, 1'b1, 0);
    idle(0);
    @(negedge clk);
`ifdef WB_X0_FILTER_EN
    check("x0_wEnable", 32'(wEnable), 32'd0);
`else
    check("x0_wEnable", 32'(wEnable), 32'd1);
`endif

    repeat (3) idle(0);
    @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
